// File: rtl/hazard_pkg.sv
// ============================================================================
// Module  : hazard_pkg
// Brief   : Shared Tnew/Tuse constants, record type and select-width helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

    localparam int DEF_TW = 2;

    localparam logic [DEF_TW-1:0] T_ALU  = 2'd1;
    localparam logic [DEF_TW-1:0] T_LOAD = 2'd2;
    localparam logic [DEF_TW-1:0] T_PC   = 2'd0;

    localparam logic [DEF_TW-1:0] U_CMP   = 2'd0;
    localparam logic [DEF_TW-1:0] U_ALU   = 2'd1;
    localparam logic [DEF_TW-1:0] U_STORE = 2'd2;

    // Tnew is kept beside the record so its width can follow the TW parameter.
    typedef struct packed {
        logic       valid;
        logic       we;
        logic [4:0] a3;
    } rec_t;

    function automatic int sel_width(input int nstage);
        return $clog2(nstage + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_match.sv
// ============================================================================
// Module  : hazard_match
// Brief   : Youngest-record priority search for one source register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_match #(
    parameter int NREC = 3,
    parameter int BASE = 1,
    parameter int TW   = 2,
    parameter int SW   = 2
) (
    input  logic [NREC-1:0]    rec_valid,
    input  logic [NREC-1:0]    rec_we,
    input  logic [5*NREC-1:0]  rec_a3,
    input  logic [TW*NREC-1:0] rec_tnew,
    input  logic [4:0]         ra,
    output logic               hit,
    output logic [SW-1:0]      k,
    output logic [TW-1:0]      tnew
);

    // Scan oldest to youngest so the youngest hit overwrites any older one.
    always_comb begin
        hit  = 1'b0;
        k    = '0;
        tnew = '0;
        for (int i = NREC - 1; i >= 0; i--) begin
            if (rec_valid[i] && rec_we[i] && (rec_a3[5*i +: 5] == ra) && (ra != 5'd0)) begin
                hit  = 1'b1;
                k    = SW'(BASE + i);
                tnew = rec_tnew[TW*i +: TW];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module  : hazard_scoreboard
// Brief   : In-flight write record file, decode stall and forwarding selects.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int NREAD  = 2,
    parameter int TW     = DEF_TW,
    localparam int SW    = sel_width(NSTAGE)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hold,
    input  logic                id_valid,
    input  logic                id_we,
    input  logic [4:0]          id_a3,
    input  logic [TW-1:0]       id_tnew,
    input  logic [NREAD-1:0]    id_rd_en,
    input  logic [5*NREAD-1:0]  id_ra,
    input  logic [TW*NREAD-1:0] id_tuse,
    output logic                stall,
    output logic [SW*NREAD-1:0] id_fwd_sel,
    output logic [SW*NREAD-1:0] ex_fwd_sel,
    output logic [31:0]         stall_cnt
);

    rec_t               r_rec  [1:NSTAGE];
    logic [TW-1:0]      r_tnew [1:NSTAGE];
    logic [5*NREAD-1:0] r_ra1;
    logic [31:0]        r_stall_cnt;

    logic [NSTAGE-1:0]    w_valid;
    logic [NSTAGE-1:0]    w_we;
    logic [5*NSTAGE-1:0]  w_a3;
    logic [TW*NSTAGE-1:0] w_tnew;
    logic [NREAD-1:0]     w_port_stall;
    logic                 w_stall;

    for (genvar s = 1; s <= NSTAGE; s++) begin : g_flat
        assign w_valid[s-1]         = r_rec[s].valid;
        assign w_we[s-1]            = r_rec[s].we;
        assign w_a3[5*(s-1) +: 5]   = r_rec[s].a3;
        assign w_tnew[TW*(s-1) +: TW] = r_tnew[s];
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        logic          w_id_hit;
        logic [SW-1:0] w_id_k;
        logic [TW-1:0] w_id_tnew;
        logic          w_ex_hit;
        logic [SW-1:0] w_ex_k;
        logic [TW-1:0] w_ex_tnew;

        hazard_match #(
            .NREC (NSTAGE),
            .BASE (1),
            .TW   (TW),
            .SW   (SW)
        ) u_id_match (
            .rec_valid (w_valid),
            .rec_we    (w_we),
            .rec_a3    (w_a3),
            .rec_tnew  (w_tnew),
            .ra        (id_ra[5*p +: 5]),
            .hit       (w_id_hit),
            .k         (w_id_k),
            .tnew      (w_id_tnew)
        );

        // The EX consumer never sees stage 1: that record is the consumer itself.
        hazard_match #(
            .NREC (NSTAGE - 1),
            .BASE (2),
            .TW   (TW),
            .SW   (SW)
        ) u_ex_match (
            .rec_valid (w_valid[NSTAGE-1:1]),
            .rec_we    (w_we[NSTAGE-1:1]),
            .rec_a3    (w_a3[5*NSTAGE-1:5]),
            .rec_tnew  (w_tnew[TW*NSTAGE-1:TW]),
            .ra        (r_ra1[5*p +: 5]),
            .hit       (w_ex_hit),
            .k         (w_ex_k),
            .tnew      (w_ex_tnew)
        );

        assign w_port_stall[p] = w_id_hit && id_rd_en[p] && (w_id_tnew > id_tuse[TW*p +: TW]);
        assign id_fwd_sel[SW*p +: SW] = (w_id_hit && (w_id_tnew == '0)) ? w_id_k : '0;
        assign ex_fwd_sel[SW*p +: SW] =
            (r_rec[1].valid && w_ex_hit && (w_ex_tnew == '0)) ? w_ex_k : '0;
    end

    assign w_stall   = id_valid && (|w_port_stall);
    assign stall     = w_stall;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 1; s <= NSTAGE; s++) begin
                r_rec[s]  <= '0;
                r_tnew[s] <= '0;
            end
            r_ra1       <= '0;
            r_stall_cnt <= '0;
        end else if (!hold) begin
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            for (int s = NSTAGE; s >= 2; s--) begin
                r_rec[s]  <= r_rec[s-1];
                r_tnew[s] <= (r_tnew[s-1] == '0) ? '0 : r_tnew[s-1] - 1'b1;
            end
            if (id_valid && !w_stall) begin
                r_rec[1]  <= '{valid: 1'b1, we: id_we, a3: id_a3};
                r_tnew[1] <= id_tnew;
                r_ra1     <= id_ra;
            end else begin
                r_rec[1]  <= '0;
                r_tnew[1] <= '0;
                r_ra1     <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module  : tb_hazard_scoreboard
// Brief   : Directed vector table plus hold and reset sequences.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset, hold, id_valid, id_we;
    logic [4:0]  id_a3;
    logic [1:0]  id_tnew;
    logic [1:0]  id_rd_en;
    logic [9:0]  id_ra;
    logic [3:0]  id_tuse;
    logic        stall;
    logic [3:0]  id_fwd_sel, ex_fwd_sel;
    logic [31:0] stall_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NSTAGE(3), .NREAD(2), .TW(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .hold       (hold),
        .id_valid   (id_valid),
        .id_we      (id_we),
        .id_a3      (id_a3),
        .id_tnew    (id_tnew),
        .id_rd_en   (id_rd_en),
        .id_ra      (id_ra),
        .id_tuse    (id_tuse),
        .stall      (stall),
        .id_fwd_sel (id_fwd_sel),
        .ex_fwd_sel (ex_fwd_sel),
        .stall_cnt  (stall_cnt)
    );

    typedef struct {
        logic       valid, we;
        logic [4:0] a3;
        logic [1:0] tnew, rd_en;
        logic [4:0] ra0, ra1;
        logic [1:0] tu0, tu1;
        logic       e_stall;
        logic [3:0] e_id, e_ex;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input logic v, we, input logic [4:0] a3, input logic [1:0] tn,
                                input logic [1:0] rd, input logic [4:0] r0, r1,
                                input logic [1:0] u0, u1, input logic es,
                                input logic [3:0] ei, ee, input logic [31:0] ec);
        vec_t t;
        t.valid = v; t.we = we; t.a3 = a3; t.tnew = tn; t.rd_en = rd;
        t.ra0 = r0; t.ra1 = r1; t.tu0 = u0; t.tu1 = u1;
        t.e_stall = es; t.e_id = ei; t.e_ex = ee; t.e_cnt = ec;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drv(input logic v, we, input logic [4:0] a3, input logic [1:0] tn,
                       input logic [1:0] rd, input logic [4:0] r0, r1, input logic [1:0] u0, u1);
        id_valid = v; id_we = we; id_a3 = a3; id_tnew = tn;
        id_rd_en = rd; id_ra = {r1, r0}; id_tuse = {u1, u0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // add $8 -> beq $8,$0
        vecs[0]  = mk(1, 1,  8, 1, 2'b11,  9, 10, 1, 1, 0, 4'b0000, 4'b0000, 0);
        vecs[1]  = mk(1, 0,  0, 0, 2'b11,  8,  0, 0, 0, 1, 4'b0000, 4'b0000, 0);
        vecs[2]  = mk(1, 0,  0, 0, 2'b11,  8,  0, 0, 0, 0, 4'b0010, 4'b0000, 1);
        vecs[3]  = mk(0, 0,  0, 0, 2'b00,  0,  0, 0, 0, 0, 4'b0000, 4'b0011, 1);
        // lw $9 -> addu $10,$9,$0
        vecs[4]  = mk(1, 1,  9, 2, 2'b01,  4,  0, 1, 0, 0, 4'b0000, 4'b0000, 1);
        vecs[5]  = mk(1, 1, 10, 1, 2'b11,  9,  0, 1, 1, 1, 4'b0000, 4'b0000, 1);
        vecs[6]  = mk(1, 1, 10, 1, 2'b11,  9,  0, 1, 1, 0, 4'b0000, 4'b0000, 2);
        vecs[7]  = mk(0, 0,  0, 0, 2'b00,  0,  0, 0, 0, 0, 4'b0000, 4'b0011, 2);
        // jal -> jr $31
        vecs[8]  = mk(1, 1, 31, 0, 2'b00,  0,  0, 0, 0, 0, 4'b0000, 4'b0000, 2);
        vecs[9]  = mk(1, 0,  0, 0, 2'b01, 31,  0, 0, 0, 0, 4'b0001, 4'b0000, 2);
        // writer to $0, then read of $0
        vecs[10] = mk(1, 1,  0, 0, 2'b00,  0,  0, 0, 0, 0, 4'b0000, 4'b0010, 2);
        vecs[11] = mk(1, 0,  0, 0, 2'b11,  0,  0, 0, 0, 0, 4'b0000, 4'b0000, 2);
        // two writers to $5, youngest wins at both consumer points
        vecs[12] = mk(1, 1,  5, 0, 2'b00,  0,  0, 0, 0, 0, 4'b0000, 4'b0000, 2);
        vecs[13] = mk(1, 1,  5, 0, 2'b00,  0,  0, 0, 0, 0, 4'b0000, 4'b0000, 2);
        vecs[14] = mk(1, 0,  0, 0, 2'b11,  5,  5, 1, 1, 0, 4'b0101, 4'b0000, 2);
        vecs[15] = mk(0, 0,  0, 0, 2'b00,  0,  0, 0, 0, 0, 4'b0000, 4'b1010, 2);

        reset = 1'b1; hold = 1'b0;
        drv(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        #4;
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_id_sel", {28'd0, id_fwd_sel}, 32'd0);
        chk("reset_ex_sel", {28'd0, ex_fwd_sel}, 32'd0);
        chk("reset_cnt", stall_cnt, 32'd0);
        tick();

        for (int i = 0; i < 16; i++) begin
            drv(vecs[i].valid, vecs[i].we, vecs[i].a3, vecs[i].tnew, vecs[i].rd_en,
                vecs[i].ra0, vecs[i].ra1, vecs[i].tu0, vecs[i].tu1);
            #4;
            chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].e_stall});
            chk($sformatf("v%0d_id_sel", i), {28'd0, id_fwd_sel}, {28'd0, vecs[i].e_id});
            chk($sformatf("v%0d_ex_sel", i), {28'd0, ex_fwd_sel}, {28'd0, vecs[i].e_ex});
            chk($sformatf("v%0d_cnt", i), stall_cnt, vecs[i].e_cnt);
            tick();
        end

        // lw $9 in stage 1, dependent decode frozen by hold for three edges
        drv(1, 1, 9, 2, 2'b00, 0, 0, 0, 0);
        tick();
        drv(1, 1, 10, 1, 2'b01, 9, 0, 1, 1);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #4;
            chk($sformatf("hold%0d_stall", i), {31'd0, stall}, 32'd1);
            chk($sformatf("hold%0d_cnt", i), stall_cnt, 32'd2);
            tick();
        end
        hold = 1'b0;
        #4;
        chk("release_stall", {31'd0, stall}, 32'd1);
        chk("release_cnt", stall_cnt, 32'd2);
        tick();
        #4;
        chk("after_stall", {31'd0, stall}, 32'd0);
        chk("after_id_sel", {28'd0, id_fwd_sel}, 32'd0);
        chk("after_cnt", stall_cnt, 32'd3);
        tick();

        // Fill with loads to $7, stall a branch on $7, then reset with hold high
        for (int i = 0; i < 3; i++) begin
            drv(1, 1, 7, 2, 2'b00, 0, 0, 0, 0);
            tick();
        end
        drv(1, 0, 0, 0, 2'b01, 7, 0, 0, 0);
        #4;
        chk("pre_reset_stall", {31'd0, stall}, 32'd1);
        tick();
        reset = 1'b1; hold = 1'b1;
        tick();
        reset = 1'b0; hold = 1'b0;
        #4;
        chk("post_reset_stall", {31'd0, stall}, 32'd0);
        chk("post_reset_id_sel", {28'd0, id_fwd_sel}, 32'd0);
        chk("post_reset_ex_sel", {28'd0, ex_fwd_sel}, 32'd0);
        chk("post_reset_cnt", stall_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the in-order MIPS pipeline. It tracks every in-flight register write in a per-stage record file with a countdown of cycles until the result can be forwarded (Tnew). It compares the decode stage's and EX stage's source registers against those records and produces the decode stall and forwarding selects for both consumer points. It sits beside the pipeline registers, is fed from decode, and drives the ID/EX bubble insert and the CMP/ALU operand muxes.

## Interface
- NSTAGE, 3: tracked stages after decode; 1 = EX, NSTAGE = last stage before RF write.
- NREAD, 2: source-register read ports per instruction.
- TW, 2: width of Tnew/Tuse fields.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- hold  in  1  global freeze (e.g. multiplier busy); no stage advances.
- id_valid  in  1  decode slot holds a real instruction.
- id_we  in  1  decode instruction writes the RF.
- id_a3  in  5  destination register.
- id_tnew  in  TW  cycles after EX entry until the result is forwardable (ALU 1, load 2, jal 0).
- id_rd_en  in  NREAD  per-port read enable.
- id_ra  in  5*NREAD  source register addresses, port p at [5p+4:5p].
- id_tuse  in  TW*NREAD  per-port cycles after decode until the value is needed (branch/jr 0, ALU 1, store data 2).
- stall  out  1  hold PC and IF/ID; insert a bubble into EX.
- id_fwd_sel  out  SW*NREAD  decode-point select; 0 = RF, k = result register of stage k.
- ex_fwd_sel  out  SW*NREAD  EX-point select; 0 = ID/EX value, k = stage k (k ≥ 2).
- stall_cnt  out  32  count of stall cycles.
- SW = $clog2(NSTAGE+1).

## Operation
- Each record k holds valid, we, a3, tnew, ra[NREAD], rd_en[NREAD].
- Advance happens on each edge with hold=0:
  - Record k moves to k+1, with tnew decremented and saturating at 0.
  - Record NSTAGE retires. The RF writes through, so there is no forwarding from retired records.
  - Stage 1 loads the decode fields when id_valid & !stall. Otherwise stage 1 loads a bubble (valid=0).
- hold=1: all records keep their values, including tnew.
- Match at port p, with source r: the youngest (smallest k) record with valid & we & a3==r & r!=0. Only one match is used.
- Decode point:
  - stall contribution = match & rd_en & (tnew_k > tuse_p).
  - id_fwd_sel = k if match & tnew_k==0, else 0.
  - A match with 0 < tnew_k ≤ tuse_p gives select 0 and no stall; the EX point resolves it later.
- EX point:
  - For record 1's ports, search stages 2..NSTAGE only.
  - ex_fwd_sel = k if match & tnew_k==0, else 0.
  - If record 1 is invalid, ex_fwd_sel = 0.
- stall = OR over ports, gated by id_valid.
- stall_cnt increments when stall & !hold, and wraps at 2^32.
- Reads of $0 never match and never stall.

## Timing
- All outputs are combinational from the record file and decode inputs. A record written at edge n is visible from cycle n+1.
- Load-use (tnew 2, tuse 1): exactly 1 stall cycle. ALU to branch (tnew 1, tuse 0): 1 cycle. Load to branch: 2 cycles.
- Reset values: every record invalid, stall=0, all selects 0, stall_cnt=0. A reset asserted mid-stall takes effect at the same edge; stall=0 the next cycle.
- reset has priority over hold. hold=1 with stall=1 keeps stall asserted and leaves stall_cnt frozen.

## Structure
- Shared package `hazard_pkg`:
  - TW default.
  - Tnew constants: T_ALU=1, T_LOAD=2, T_PC=0.
  - Tuse constants: U_CMP=0, U_ALU=1, U_STORE=2.
  - Record struct.
  - SW function.
- Sub-module `hazard_match`: parametrised youngest-match priority search over a stage range. It returns hit, k and tnew_k, and is instantiated once per port per consumer point (2·NREAD instances).
- Top module: record shift register, stall OR tree, counter.

## Test plan
- add $8 then beq $8,$0: the cycle after add enters EX, stall=1 (tnew 1 > 0). The next cycle has stall=0 and id_fwd_sel[0]=2; stall_cnt=1.
- lw $9 then addu $10,$9,$0:
  - Cycle after lw enters EX: stall=1.
  - Next cycle: stall=0, id_fwd_sel=0 (tnew 1 ≤ tuse 1).
  - When addu is in EX: ex_fwd_sel[0]=3.
- jal (a3=31, tnew 0) then jr $31: stall=0, id_fwd_sel[0]=1.
- Writer to $0 followed by a read of $0: stall=0 and all selects 0. Writers to $5 in stages 1 (tnew 0) and 2 (tnew 0): id_fwd_sel=1.
- lw in stage 1 with a dependent decode and hold=1 for 3 cycles: records unchanged, stall stays 1, stall_cnt unchanged. After release, exactly one counted stall.
- Pipeline full of valid writers, reset=1 for one edge: the next cycle has all records invalid, stall=0 and stall_cnt=0.
